// File: rtl/multi_ball_engine.sv
// multi_ball_engine
// Holds position and motion for N balls. The ball selected by SelBall is
// steered by the USB keycode, the rest keep their motion and bounce off the
// screen edges. One ball is committed per clock after each frame tick.
//
// Ports:
//   Clk        system clock, all state on its rising edge
//   Reset      synchronous active-high reset
//   frame_clk  VGA vertical sync (asynchronous, sampled)
//   keycode    current USB HID keycode
//   SelBall    index of the steered ball (values >= N steer nothing)
//   BallX      packed X centres, ball i at [10i+9:10i]
//   BallY      packed Y centres, same packing
//   BallS      ball radius (constant SIZE)
//   Busy       high while a frame update (UPDATE or DONE) is in progress
//   FrameDone  one-cycle pulse after the last ball is committed
//   Overrun    sticky flag, set when a frame tick is lost
module multi_ball_engine #(
  parameter int N     = 4,
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479,
  parameter int SIZE  = 4,
  parameter int STEP  = 1,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [7:0]        keycode,
  input  logic [SEL_W-1:0]  SelBall,
  output logic [10*N-1:0]   BallX,
  output logic [10*N-1:0]   BallY,
  output logic [9:0]        BallS,
  output logic              Busy,
  output logic              FrameDone,
  output logic              Overrun
);

  localparam logic [9:0] STEP_POS = 10'(STEP);
  localparam logic [9:0] STEP_NEG = 10'(-STEP);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t state, next_state;

  logic sync1, sync2, sync_dly, tick;
  logic pending, pending_next, overrun_next, start_frame;
  logic [SEL_W-1:0] idx;
  logic [7:0] frame_key;
  logic [SEL_W-1:0] frame_sel;

  logic [9:0] ball_x [N];
  logic [9:0] ball_y [N];
  logic [9:0] mot_x  [N];
  logic [9:0] mot_y  [N];
  logic [9:0] new_mx, new_my;

  // Rising edge of the synchronised vsync marks the end of the blanking pulse.
  assign tick = sync2 & ~sync_dly;

  assign BallS     = 10'(SIZE);
  assign Busy      = (state != IDLE);
  assign FrameDone = (state == DONE);

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign BallX[10*g +: 10] = ball_x[g];
    assign BallY[10*g +: 10] = ball_y[g];
  end

  // A tick arriving while busy is parked in 'pending'; a second one is lost.
  // A tick landing exactly in DONE with nothing pending starts the next frame
  // straight away, which is the same as parking it and consuming it at once.
  always_comb begin
    next_state   = state;
    pending_next = pending;
    overrun_next = Overrun;
    start_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          next_state  = UPDATE;
          start_frame = 1'b1;
        end
      end
      UPDATE: begin
        if (idx == SEL_W'(N - 1)) next_state = DONE;
        if (tick) begin
          if (pending) overrun_next = 1'b1;
          else         pending_next = 1'b1;
        end
      end
      DONE: begin
        if (pending) begin
          next_state   = UPDATE;
          start_frame  = 1'b1;
          pending_next = 1'b0;
          if (tick) overrun_next = 1'b1;
        end else if (tick) begin
          next_state  = UPDATE;
          start_frame = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Motion for the ball at idx: steering first, then a wall bounce on the
  // pre-move position overrides only the axis that hit the wall.
  always_comb begin
    new_mx = mot_x[idx];
    new_my = mot_y[idx];
    if (frame_sel == idx) begin
      case (frame_key)
        8'h1A: begin new_mx = 10'd0;    new_my = STEP_NEG; end
        8'h16: begin new_mx = 10'd0;    new_my = STEP_POS; end
        8'h04: begin new_mx = STEP_NEG; new_my = 10'd0;    end
        8'h07: begin new_mx = STEP_POS; new_my = 10'd0;    end
        default: ;
      endcase
    end
    if (({1'b0, ball_y[idx]} + 11'(SIZE)) >= 11'(Y_MAX)) new_my = STEP_NEG;
    else if (ball_y[idx] <= 10'(SIZE))                     new_my = STEP_POS;
    if (({1'b0, ball_x[idx]} + 11'(SIZE)) >= 11'(X_MAX)) new_mx = STEP_NEG;
    else if (ball_x[idx] <= 10'(SIZE))                     new_mx = STEP_POS;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_dly  <= 1'b0;
      pending   <= 1'b0;
      Overrun   <= 1'b0;
      idx       <= '0;
      frame_key <= 8'd0;
      frame_sel <= '0;
      for (int i = 0; i < N; i++) begin
        ball_x[i] <= 10'(((i + 1) * X_MAX) / (N + 1));
        ball_y[i] <= 10'(Y_MAX / 2);
        mot_x[i]  <= 10'd0;
        mot_y[i]  <= 10'd0;
      end
    end else begin
      sync1    <= frame_clk;
      sync2    <= sync1;
      sync_dly <= sync2;
      state    <= next_state;
      pending  <= pending_next;
      Overrun  <= overrun_next;
      if (start_frame) begin
        idx       <= '0;
        frame_key <= keycode;
        frame_sel <= SelBall;
      end else if (state == UPDATE) begin
        idx <= idx + SEL_W'(1);
      end
      if (state == UPDATE) begin
        mot_x[idx]  <= new_mx;
        mot_y[idx]  <= new_my;
        ball_x[idx] <= ball_x[idx] + new_mx;
        ball_y[idx] <= ball_y[idx] + new_my;
      end
    end
  end

endmodule

// File: tb/tb_multi_ball_engine.sv
// Testbench for multi_ball_engine: a 4-ball instance with a scoreboard of
// expected positions per frame, plus a 3-ball instance whose select is out
// of range.
module tb_multi_ball_engine;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'd0;
  logic [1:0]  sel4 = 2'd0;
  logic [1:0]  sel3 = 2'd3;

  logic [39:0] bx4, by4;
  logic [9:0]  bs4;
  logic        busy4, done4, ovr4;
  logic [29:0] bx3, by3;
  logic [9:0]  bs3;
  logic        busy3, done3, ovr3;

  int pass_count = 0;
  int total_count = 0;
  int fail_count = 0;

  // Reference model of the 4-ball instance
  int px [4];
  int py [4];
  int vx [4];
  int vy [4];
  logic [39:0] exp_x_q [$];
  logic [39:0] exp_y_q [$];

  localparam logic [39:0] RST_X4 = {10'd511, 10'd383, 10'd255, 10'd127};
  localparam logic [39:0] RST_Y4 = {10'd239, 10'd239, 10'd239, 10'd239};
  localparam logic [29:0] RST_X3 = {10'd479, 10'd319, 10'd159};
  localparam logic [29:0] RST_Y3 = {10'd239, 10'd239, 10'd239};

  always #5 Clk = ~Clk;

  multi_ball_engine #(.N(4)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .SelBall(sel4), .BallX(bx4), .BallY(by4), .BallS(bs4),
    .Busy(busy4), .FrameDone(done4), .Overrun(ovr4)
  );

  multi_ball_engine #(.N(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .SelBall(sel3), .BallX(bx3), .BallY(by3), .BallS(bs3),
    .Busy(busy3), .FrameDone(done3), .Overrun(ovr3)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      px[i] = ((i + 1) * 639) / 5;
      py[i] = 239;
      vx[i] = 0;
      vy[i] = 0;
    end
    exp_x_q.delete();
    exp_y_q.delete();
  endtask

  // Advance the model by one frame and push the expected packed positions.
  task automatic model_frame(input logic [7:0] key, input int sel);
    logic [39:0] ex, ey;
    for (int k = 0; k < 4; k++) begin
      if (k == sel) begin
        case (key)
          8'h1A: begin vx[k] = 0;  vy[k] = -1; end
          8'h16: begin vx[k] = 0;  vy[k] = 1;  end
          8'h04: begin vx[k] = -1; vy[k] = 0;  end
          8'h07: begin vx[k] = 1;  vy[k] = 0;  end
          default: ;
        endcase
      end
      if (py[k] + 4 >= 479) vy[k] = -1;
      else if (py[k] <= 4)  vy[k] = 1;
      if (px[k] + 4 >= 639) vx[k] = -1;
      else if (px[k] <= 4)  vx[k] = 1;
      px[k] = (px[k] + vx[k] + 1024) % 1024;
      py[k] = (py[k] + vy[k] + 1024) % 1024;
    end
    for (int k = 0; k < 4; k++) begin
      ex[10*k +: 10] = 10'(px[k]);
      ey[10*k +: 10] = 10'(py[k]);
    end
    exp_x_q.push_back(ex);
    exp_y_q.push_back(ey);
  endtask

  task automatic compare_frame(input string tag);
    logic [39:0] ex, ey;
    total_count++;
    assert (exp_x_q.size() > 0) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s_queue: observed empty expected entry", tag);
    end
    if (exp_x_q.size() > 0) begin
      ex = exp_x_q.pop_front();
      ey = exp_y_q.pop_front();
      check_output({tag, "_x"}, 80'(bx4), 80'(ex));
      check_output({tag, "_y"}, 80'(by4), 80'(ey));
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    frame_clk = 1'b0;
    step();
    step();
    Reset = 1'b0;
    model_reset();
  endtask

  // Drive one frame pulse, wait (bounded) for FrameDone, then score it.
  task automatic apply_stimulus(input logic [7:0] key, input logic [1:0] sel);
    bit seen;
    keycode = key;
    sel4 = sel;
    model_frame(key, int'(sel));
    frame_clk = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      step();
      if (n == 1) frame_clk = 1'b0;
      if (done4) seen = 1'b1;
    end
    frame_clk = 1'b0;
    check_output("frame_done_seen", 80'(seen), 80'(1));
    repeat (4) step();
    compare_frame("frame");
  endtask

  initial begin
    int first, busy_n, done_n, last_busy, guard;
    int busy_log [24];
    int done_log [24];
    int y2_log [24];

    $display("[TB] multi_ball_engine bench start");

    // 1. Reset
    step();
    apply_reset();
    check_output("rst_x", 80'(bx4), 80'(RST_X4));
    check_output("rst_y", 80'(by4), 80'(RST_Y4));
    check_output("rst_size", 80'(bs4), 80'(4));
    check_output("rst_busy", 80'(busy4), 80'(0));
    check_output("rst_done", 80'(done4), 80'(0));
    check_output("rst_ovr", 80'(ovr4), 80'(0));
    check_output("rst3_x", 80'(bx3), 80'(RST_X3));
    repeat (3) step();

    // 2. Steering with cycle-accurate timing
    keycode = 8'h1A;
    sel4 = 2'd2;
    model_frame(8'h1A, 2);
    frame_clk = 1'b1;
    first = -1;
    for (int c = 1; c < 16; c++) begin
      step();
      if (c == 2) frame_clk = 1'b0;
      busy_log[c] = int'(busy4);
      done_log[c] = int'(done4);
      y2_log[c]   = int'(by4[29:20]);
      if (busy4 && first < 0) begin
        first = c;
        keycode = 8'h16;
      end
    end
    check_output("t2_busy_start", 80'(first == 3 || first == 4), 80'(1));
    if (first < 1 || first > 8) first = 3;
    check_output("t2_busy_before", 80'(busy_log[first-1]), 80'(0));
    check_output("t2_busy_t5", 80'(busy_log[first+4]), 80'(1));
    check_output("t2_busy_after", 80'(busy_log[first+5]), 80'(0));
    check_output("t2_done_t4", 80'(done_log[first+3]), 80'(0));
    check_output("t2_done_t5", 80'(done_log[first+4]), 80'(1));
    check_output("t2_done_t6", 80'(done_log[first+5]), 80'(0));
    check_output("t2_y2_t3", 80'(y2_log[first+2]), 80'(239));
    check_output("t2_y2_t4", 80'(y2_log[first+3]), 80'(238));
    repeat (3) step();
    compare_frame("t2_first");
    for (int f = 0; f < 10; f++) apply_stimulus(8'h1A, 2'd2);
    check_output("t2_y2_after10", 80'(by4[29:20]), 80'(228));
    check_output("t2_x_unchanged", 80'(bx4), 80'(RST_X4));

    // 3. Bottom bounce
    apply_reset();
    guard = 0;
    while (py[0] != 475 && guard < 300) begin
      apply_stimulus(8'h16, 2'd0);
      guard++;
    end
    check_output("t3_y0_475", 80'(by4[9:0]), 80'(475));
    apply_stimulus(8'h16, 2'd0);
    check_output("t3_y0_474", 80'(by4[9:0]), 80'(474));
    apply_stimulus(8'h16, 2'd0);
    check_output("t3_y0_475b", 80'(by4[9:0]), 80'(475));
    apply_stimulus(8'h16, 2'd0);
    check_output("t3_y0_474b", 80'(by4[9:0]), 80'(474));

    // 4. Overrun: three rising edges two cycles apart inside one update
    apply_reset();
    keycode = 8'h00;
    sel4 = 2'd0;
    model_frame(8'h00, 0);
    model_frame(8'h00, 0);
    busy_n = 0;
    done_n = 0;
    first = -1;
    last_busy = -1;
    for (int c = 0; c < 20; c++) begin
      frame_clk = (c < 6) && (c % 2 == 0);
      step();
      if (busy4) begin
        busy_n++;
        last_busy = c;
        if (first < 0) first = c;
      end
      if (done4) done_n++;
    end
    frame_clk = 1'b0;
    check_output("t4_busy_cycles", 80'(busy_n), 80'(10));
    check_output("t4_busy_contig", 80'(last_busy - first), 80'(9));
    check_output("t4_done_pulses", 80'(done_n), 80'(2));
    check_output("t4_overrun", 80'(ovr4), 80'(1));
    compare_frame("t4_f1");
    compare_frame("t4_f2");
    repeat (4) step();
    apply_stimulus(8'h07, 2'd1);
    check_output("t4_overrun_sticky", 80'(ovr4), 80'(1));
    apply_reset();
    check_output("t4_overrun_clr", 80'(ovr4), 80'(0));

    // 5. Reset mid-update
    apply_stimulus(8'h1A, 2'd2);
    keycode = 8'h04;
    sel4 = 2'd1;
    frame_clk = 1'b1;
    first = -1;
    for (int n = 0; n < 20 && first < 0; n++) begin
      step();
      if (n == 1) frame_clk = 1'b0;
      if (busy4) first = n;
    end
    frame_clk = 1'b0;
    check_output("t5_busy_seen", 80'(first >= 0), 80'(1));
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_output("t5_busy_low", 80'(busy4), 80'(0));
    check_output("t5_x_rst", 80'(bx4), 80'(RST_X4));
    check_output("t5_y_rst", 80'(by4), 80'(RST_Y4));
    done_n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done4) done_n++;
    end
    check_output("t5_no_done", 80'(done_n), 80'(0));
    model_reset();

    // 6. Out-of-range select on the 3-ball instance
    apply_reset();
    sel3 = 2'd3;
    for (int f = 0; f < 5; f++) apply_stimulus(8'h07, 2'd0);
    check_output("t6_x3", 80'(bx3), 80'(RST_X3));
    check_output("t6_y3", 80'(by3), 80'(RST_Y3));
    check_output("t6_ovr3", 80'(ovr3), 80'(0));
    check_output("t6_busy3", 80'(busy3), 80'(0));

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/multi_ball_engine.md
# multi_ball_engine

Parametrised successor to the single-ball motion block. It holds position and motion state for `N` balls. One ball is steered by the USB keycode and the others bounce freely. All balls advance once per video frame. The block sits between the NIOS keycode PIO / `vga_controller` vertical sync and the colour mapper. It runs entirely on the 50 MHz system clock and treats vertical sync as a sampled input, not as a clock.

## Interface
- `N`, 4: number of balls (1..16).
- `X_MAX`, 639: rightmost pixel column.
- `Y_MAX`, 479: bottom pixel row.
- `SIZE`, 4: ball radius in pixels, same for all balls.
- `STEP`, 1: pixels moved per frame on each moving axis (1..15).
- `Clk`  in  1  system clock (MAX10_CLK1_50). One clock; all state on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_clk`  in  1  VGA vertical sync, asynchronous to `Clk`.
- `keycode`  in  8  current USB HID keycode.
- `SelBall`  in  $clog2(N) (min 1)  index of the steered ball. Values ≥ N steer no ball.
- `BallX`  out  10·N  packed X centres; ball i is at [10i+9:10i].
- `BallY`  out  10·N  packed Y centres, same packing.
- `BallS`  out  10  radius, constant `SIZE`.
- `Busy`  out  1  high while a frame update is in progress.
- `FrameDone`  out  1  one-cycle pulse after the last ball is committed.
- `Overrun`  out  1  sticky; set when a frame edge is lost.

## Operation
- **Frame edge detection.**
  - `frame_clk` passes through a 2-FF synchroniser, then a delay register.
  - A tick is raised on the synchronised rising edge, i.e. at the end of the active-low vsync.
- **Reset values.**
  - Ball i: X = (i+1)·X_MAX/(N+1) (integer division), Y = Y_MAX/2.
  - All motion registers are 0.
  - `Busy`, `FrameDone` and `Overrun` are 0; the FSM is in IDLE.
- **FSM states: IDLE, UPDATE, DONE.**
  - IDLE → UPDATE on a tick. On the same edge: capture `keycode` and `SelBall` into frame registers, and set idx = 0.
  - UPDATE: commit ball idx on each cycle and increment idx. After idx = N-1, go to DONE.
  - DONE: `FrameDone` is high for this single cycle.
  - DONE → UPDATE (idx = 0, recapture inputs) if a pending tick is set, and clear pending. Otherwise DONE → IDLE.
- **Tick during UPDATE/DONE.**
  - If pending is clear, set pending.
  - If pending is already set, discard the tick and set `Overrun`. `Overrun` clears only on `Reset`.
- **Per-ball update, ball k, with motion (mx, my) in 10-bit two's complement.**
  - **Steering** applies only when k equals the captured `SelBall`:
    - 0x1A (W): (0, −STEP)
    - 0x16 (S): (0, +STEP)
    - 0x04 (A): (−STEP, 0)
    - 0x07 (D): (+STEP, 0)
    - Any other code: motion unchanged.
  - **Bounce** is evaluated on the current position after steering. It overrides only the affected axis.
    - Y + SIZE ≥ Y_MAX → my = −STEP.
    - Y ≤ SIZE → my = +STEP.
    - X + SIZE ≥ X_MAX → mx = −STEP.
    - X ≤ SIZE → mx = +STEP.
  - **Commit:** new motion is stored; X ← X + mx, Y ← Y + my (mod 2¹⁰). No clamping is needed while STEP < SIZE.
- **Unsteered and zero-motion balls.** Unsteered balls keep their motion. A ball with zero motion stays put unless it is at a wall.
- **Reset mid-UPDATE.** Everything returns to the reset values on the next edge, including balls already committed this frame. The pending flag clears.

## Timing
- Let T be the cycle in which the tick is asserted: 3 `Clk` edges after `frame_clk` rises, with at most 1 cycle of synchroniser uncertainty.
- `Busy` is high from T+1 through T+N+1, covering the UPDATE cycles plus DONE.
- Ball i outputs change from cycle T+2+i onward; they are registered with no combinational path from inputs.
- `FrameDone` is high in cycle T+N+1.
- Minimum tick spacing with no pending: N+2 cycles.
- Changes to `keycode` or `SelBall` after T have no effect until the next frame.

## Test plan
Defaults are N=4, X_MAX=639, Y_MAX=479, SIZE=4, STEP=1.

1. **Reset.** Assert `Reset` for 2 cycles → BallX = {511,383,255,127}, every Y = 239, BallS = 4, Busy/FrameDone/Overrun = 0.
2. **Steering.** SelBall=2, keycode=0x1A, one `frame_clk` pulse → ball 2 Y = 238 at T+4, other balls unchanged. FrameDone pulses at T+5 and Busy covers T+1..T+5. After 10 more frames ball 2 Y = 228.
3. **Bottom bounce.** Steer ball 0 with 0x16 until Y = 475 → on the next frame my = −1 and Y = 474. Holding 0x16 keeps it oscillating between 474 and 475.
4. **Overrun.** Hold `frame_clk` toggling every 2 cycles for 3 edges inside one update → one pending frame runs after DONE with no return to IDLE. Overrun = 1 and stays 1 until Reset.
5. **Reset mid-update.** Reset at T+3 → all balls return to their reset positions, Busy = 0 the following cycle, no FrameDone pulse.
6. **Out-of-range select.** Use N=3 with a 2-bit SelBall = 3 and keycode 0x07 → no ball changes its motion; all positions are unchanged over 5 frames.
